// File: rtl/ram_1k.sv
// ram_1k: 1024 x 8 single-port synchronous RAM with a registered read port.
// One shared address bus; each rising edge performs either a write or a read.
// Asynchronous active-high reset clears only the output register. Array
// contents survive reset and are blocked from updating while it is held.
module ram_1k #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DEPTH      = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  w_wr_en;

    // Writes are suppressed while reset is held so contents are preserved.
    assign w_wr_en = write_enable & ~rst;

    // Storage array: no reset, one word written per enabled edge.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[address] <= data_in;
        end
    end

    // Output register: cleared asynchronously, loaded only on read edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
        end else if (!write_enable) begin
            r_data_out <= r_mem[address];
        end
    end

    assign data_out = r_data_out;

endmodule

// File: tb/tb_ram_1k.sv
// tb_ram_1k: self-checking bench for ram_1k against a behavioural array model.
module tb_ram_1k;

    logic       clk;
    logic       rst;
    logic       write_enable;
    logic [9:0] address;
    logic [7:0] data_in;
    logic [7:0] data_out;

    int checks = 0;
    int errors = 0;

    // Reference model: word array, written flags, expected output register.
    logic [7:0] m_mem [1024];
    bit         m_vld [1024];
    logic [7:0] m_out;
    bit         m_out_known;

    ram_1k #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(10),
        .DEPTH     (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .write_enable(write_enable),
        .address     (address),
        .data_in     (data_in),
        .data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle (inputs set away from the edge), then update the model.
    task automatic do_op(input bit we, input int addr, input logic [7:0] din, input bit rs);
        write_enable = we;
        address      = addr[9:0];
        data_in      = din;
        rst          = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            m_out       = 8'h00;
            m_out_known = 1'b1;
        end else if (we) begin
            m_mem[addr] = din;
            m_vld[addr] = 1'b1;
        end else begin
            m_out       = m_mem[addr];
            m_out_known = m_vld[addr];
        end
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst          = 1'b1;
        write_enable = 1'b0;
        address      = '0;
        data_in      = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_init got %h exp 00", data_out);
        end
        rst         = 1'b0;
        m_out       = 8'h00;
        m_out_known = 1'b1;

        do_op(1'b1, 10, 8'h5A, 1'b0);
        do_op(1'b0, 10, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("FAIL reset_preload got %h exp 5a", data_out);
        end
        // Assert reset mid-cycle: output must clear before the next edge.
        rst = 1'b1;
        #2;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_async got %h exp 00", data_out);
        end
        // Write attempted while reset is held must be dropped.
        write_enable = 1'b1;
        address      = 10'd10;
        data_in      = 8'h77;
        @(posedge clk);
        #1;
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold got %h exp 00", data_out);
        end
        rst   = 1'b0;
        m_out = 8'h00;
        do_op(1'b0, 10, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h5A) begin
            errors++;
            $display("FAIL reset_preserve got %h exp 5a", data_out);
        end
    endtask

    task automatic test_write_read;
        do_op(1'b1, 55, 8'h56, 1'b0);
        do_op(1'b1, 66, 8'h36, 1'b0);
        checks++;
        if (data_out !== m_out) begin
            errors++;
            $display("FAIL wr_hold_out got %h exp %h", data_out, m_out);
        end
        do_op(1'b0, 66, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h36) begin
            errors++;
            $display("FAIL read66 got %h exp 36", data_out);
        end
        do_op(1'b0, 55, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h56) begin
            errors++;
            $display("FAIL read55 got %h exp 56", data_out);
        end
    endtask

    task automatic test_write_holds;
        do_op(1'b1, 55, 8'hA5, 1'b0);
        checks++;
        if (data_out !== 8'h56) begin
            errors++;
            $display("FAIL write_holds got %h exp 56", data_out);
        end
        do_op(1'b0, 55, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL reread55 got %h exp a5", data_out);
        end
    endtask

    task automatic test_boundaries;
        do_op(1'b1, 0, 8'h01, 1'b0);
        do_op(1'b1, 1023, 8'hFF, 1'b0);
        do_op(1'b0, 0, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h01) begin
            errors++;
            $display("FAIL bound_lo got %h exp 01", data_out);
        end
        do_op(1'b0, 1023, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'hFF) begin
            errors++;
            $display("FAIL bound_hi got %h exp ff", data_out);
        end
        do_op(1'b0, 0, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h01) begin
            errors++;
            $display("FAIL bound_alias got %h exp 01", data_out);
        end
    endtask

    task automatic test_streaming;
        for (int i = 0; i < 1024; i++) begin
            do_op(1'b1, i, i[7:0], 1'b0);
        end
        for (int i = 0; i < 1024; i++) begin
            do_op(1'b0, i, 8'h00, 1'b0);
            checks++;
            if (data_out !== i[7:0] || data_out !== m_out) begin
                errors++;
                $display("FAIL stream addr %0d got %h exp %h", i, data_out, i[7:0]);
            end
        end
    endtask

    task automatic test_overwrite_reset;
        do_op(1'b1, 300, 8'h11, 1'b0);
        do_op(1'b1, 300, 8'h22, 1'b0);
        do_op(1'b0, 300, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h22) begin
            errors++;
            $display("FAIL overwrite got %h exp 22", data_out);
        end
        do_op(1'b1, 300, 8'h33, 1'b1);
        checks++;
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL ovr_reset_out got %h exp 00", data_out);
        end
        do_op(1'b0, 300, 8'h00, 1'b0);
        checks++;
        if (data_out !== 8'h22) begin
            errors++;
            $display("FAIL ovr_reset_keep got %h exp 22", data_out);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 600; n++) begin
            bit         we;
            bit         rs;
            int         addr;
            logic [7:0] din;
            we   = 1'($urandom_range(0, 1));
            rs   = ($urandom_range(0, 19) == 0);
            addr = (n % 3 == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 1023));
            din  = 8'($urandom);
            do_op(we, addr, din, rs);
            if (m_out_known) begin
                checks++;
                if (data_out !== m_out) begin
                    errors++;
                    $display("FAIL random op %0d we %0b rst %0b addr %0d got %h exp %h",
                             n, we, rs, addr, data_out, m_out);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            m_vld[i] = 1'b0;
            m_mem[i] = 8'h00;
        end
        m_out       = 8'h00;
        m_out_known = 1'b0;
        test_reset();
        test_write_read();
        test_write_holds();
        test_boundaries();
        test_streaming();
        test_overwrite_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
